// File: rtl/counter_report_serializer_if.sv
// counter_report_serializer_if: counter inputs, snapshot request and byte-stream handshake
interface counter_report_serializer_if;
  logic [63:0] count0;
  logic [63:0] count1;
  logic req;
  logic ready;
  logic [7:0] data;
  logic valid;
  logic busy;
  logic done;
  logic overrun;
  modport master (
    input count0, count1, req, ready,
    output data, valid, busy, done, overrun
  );
  modport slave (
    output count0, count1, req, ready,
    input data, valid, busy, done, overrun
  );
endinterface

// File: rtl/counter_report_serializer.sv
// counter_report_serializer: snapshots two 64-bit counters and streams them as an 18-byte checksummed frame
module counter_report_serializer #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int FRAME_LEN = 18
) (
  input logic clk,
  input logic rst,
  counter_report_serializer_if.master bus
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [4:0] LAST = 5'(FRAME_LEN - 1);
  state_t state, state_nxt;
  logic [4:0] idx;
  logic [63:0] snap0, snap1;
  logic [7:0] csum, byte_sel;
  logic [2:0] sel;
  logic send, accept, last, capture, done_q, overrun_q;
  always_comb begin
    send = state == SEND;
    accept = send && bus.ready;
    last = accept && idx == LAST;
    capture = !send && bus.req;
    // indices 1-8 and 9-16 share the same low three bits of idx-1
    sel = 3'(idx - 5'd1);
    byte_sel = idx == 5'd0 ? HEADER :
               idx == LAST ? csum :
               idx <= 5'd8 ? 8'(snap0 >> {sel, 3'b000}) : 8'(snap1 >> {sel, 3'b000});
    state_nxt = capture ? SEND : last ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= 5'd0;
      snap0 <= 64'd0;
      snap1 <= 64'd0;
      csum <= 8'd0;
      done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state <= state_nxt;
      done_q <= last;
      if (bus.req && send) overrun_q <= 1'b1;
      if (capture) begin
        snap0 <= bus.count0;
        snap1 <= bus.count1;
        idx <= 5'd0;
        csum <= 8'd0;
      end else if (accept) begin
        csum <= csum ^ bus.data;
        idx <= last ? 5'd0 : idx + 5'd1;
      end
    end
  end
  assign bus.data = send ? byte_sel : 8'h00;
  assign bus.valid = send;
  assign bus.busy = send;
  assign bus.done = done_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_counter_report_serializer.sv
// tb_counter_report_serializer: directed scenario tests for the counter frame serializer
module tb_counter_report_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [7:0] got [18];
  int got_n;
  int hold_bad;
  counter_report_serializer_if bus();
  counter_report_serializer dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [63:0] c0, input logic [63:0] c1, input int i);
    logic [7:0] f [18];
    logic [7:0] x;
    f[0] = 8'hA5;
    for (int j = 0; j < 8; j++) begin
      f[1 + j] = c0[8*j +: 8];
      f[9 + j] = c1[8*j +: 8];
    end
    x = 8'h00;
    for (int j = 0; j < 17; j++) x = x ^ f[j];
    f[17] = x;
    return f[i];
  endfunction

  task automatic collect(input bit toggle, input int req_at, input int stop_n);
    logic [3:0] pat = 4'b1001;
    logic [7:0] prev = 8'h00;
    bit held = 1'b0;
    int k = 0;
    got_n = 0;
    hold_bad = 0;
    for (int cyc = 0; cyc < 400 && got_n < stop_n; cyc++) begin
      if (held && (bus.valid !== 1'b1 || bus.data !== prev)) hold_bad++;
      bus.ready = toggle ? pat[k % 4] : 1'b1;
      k++;
      if (req_at >= 0) bus.req = (got_n == req_at);
      if (bus.valid && bus.ready) begin
        got[got_n] = bus.data;
        got_n++;
        held = 1'b0;
      end else begin
        held = bus.valid;
        prev = bus.data;
      end
      tick();
    end
    if (req_at >= 0) bus.req = 1'b0;
    bus.ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.valid, bus.busy, bus.done, bus.overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {bus.valid, bus.busy, bus.done, bus.overrun});
    end
    checks++;
    if (bus.data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00", bus.data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.count0 = 64'h1;
    bus.count1 = 64'h0;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.busy !== 1'b1 || bus.data !== 8'hA5) begin
      failures++;
      $display("FAIL basic_latency got=v%b b%b d%h exp=v1 b1 dA5", bus.valid, bus.busy, bus.data);
    end
    collect(1'b0, -1, 18);
    checks++;
    if (got_n !== 18) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=18", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got[i] !== exp_byte(64'h1, 64'h0, i)) begin
        failures++;
        $display("FAIL basic_byte%0d got=%h exp=%h", i, got[i], exp_byte(64'h1, 64'h0, i));
      end
    end
    checks++;
    if (got[17] !== 8'hA4) begin
      failures++;
      $display("FAIL basic_checksum got=%h exp=a4", got[17]);
    end
    checks++;
    if ({bus.done, bus.busy, bus.valid} !== 3'b100) begin
      failures++;
      $display("FAIL basic_done got=%b exp=100", {bus.done, bus.busy, bus.valid});
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got=%b exp=0", bus.done);
    end
  endtask

  task automatic test_snapshot();
    bus.count0 = 64'h0807060504030201;
    bus.count1 = 64'h100F0E0D0C0B0A09;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    bus.count0 = '1;
    bus.count1 = '1;
    collect(1'b0, -1, 18);
    checks++;
    if (got_n !== 18) begin
      failures++;
      $display("FAIL snap_count got=%0d exp=18", got_n);
    end
    for (int i = 1; i < 17 && i < got_n; i++) begin
      checks++;
      if (got[i] !== 8'(i)) begin
        failures++;
        $display("FAIL snap_byte%0d got=%h exp=%h", i, got[i], 8'(i));
      end
    end
    checks++;
    if (got[17] !== 8'hB5) begin
      failures++;
      $display("FAIL snap_checksum got=%h exp=b5", got[17]);
    end
    tick();
  endtask

  task automatic test_ready_toggle();
    bus.count0 = 64'h1;
    bus.count1 = 64'h0;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    collect(1'b1, -1, 18);
    checks++;
    if (got_n !== 18) begin
      failures++;
      $display("FAIL toggle_count got=%0d exp=18", got_n);
    end
    checks++;
    if (hold_bad !== 0) begin
      failures++;
      $display("FAIL toggle_hold got=%0d unstable cycles exp=0", hold_bad);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got[i] !== exp_byte(64'h1, 64'h0, i)) begin
        failures++;
        $display("FAIL toggle_byte%0d got=%h exp=%h", i, got[i], exp_byte(64'h1, 64'h0, i));
      end
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL toggle_done got=%b exp=1", bus.done);
    end
    tick();
  endtask

  task automatic test_overrun();
    bus.count0 = 64'h1122334455667788;
    bus.count1 = 64'h99AABBCCDDEEFF00;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    collect(1'b0, 5, 18);
    checks++;
    if (bus.overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set got=%b exp=1", bus.overrun);
    end
    checks++;
    if (got_n !== 18) begin
      failures++;
      $display("FAIL ovr_count got=%0d exp=18", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got[i] !== exp_byte(64'h1122334455667788, 64'h99AABBCCDDEEFF00, i)) begin
        failures++;
        $display("FAIL ovr_byte%0d got=%h exp=%h", i, got[i], exp_byte(64'h1122334455667788, 64'h99AABBCCDDEEFF00, i));
      end
    end
    tick();
    tick();
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_no_second got=v%b o%b exp=v0 o1", bus.valid, bus.overrun);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear got=%b exp=0", bus.overrun);
    end
  endtask

  task automatic test_reset_mid();
    bus.count0 = 64'hDEADBEEFCAFEF00D;
    bus.count1 = 64'h0123456789ABCDEF;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    collect(1'b0, -1, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.valid, bus.busy, bus.done} !== 3'b000 || bus.data !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset got=v%b b%b d%b data=%h exp=0 0 0 00", bus.valid, bus.busy, bus.done, bus.data);
    end
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 8'hA5) begin
      failures++;
      $display("FAIL mid_restart got=v%b d%h exp=v1 dA5", bus.valid, bus.data);
    end
    collect(1'b0, -1, 18);
    checks++;
    if (got_n !== 18) begin
      failures++;
      $display("FAIL mid_count got=%0d exp=18", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got[i] !== exp_byte(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, i)) begin
        failures++;
        $display("FAIL mid_byte%0d got=%h exp=%h", i, got[i], exp_byte(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, i));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.count0 = 64'h00000000000000FF;
    bus.count1 = 64'h8000000000000001;
    bus.req = 1'b1;
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 8'hA5 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first got=v%b d%h o%b exp=v1 dA5 o0", bus.valid, bus.data, bus.overrun);
    end
    for (int f = 0; f < 2; f++) begin
      collect(1'b0, -1, 18);
      checks++;
      if (got_n !== 18) begin
        failures++;
        $display("FAIL b2b_count%0d got=%0d exp=18", f, got_n);
      end
      checks++;
      if (got[17] !== exp_byte(64'hFF, 64'h8000000000000001, 17)) begin
        failures++;
        $display("FAIL b2b_checksum%0d got=%h exp=%h", f, got[17], exp_byte(64'hFF, 64'h8000000000000001, 17));
      end
      checks++;
      if ({bus.done, bus.busy, bus.valid, bus.overrun} !== 4'b1001) begin
        failures++;
        $display("FAIL b2b_gap%0d got=%b exp=1001", f, {bus.done, bus.busy, bus.valid, bus.overrun});
      end
      if (f == 1) bus.req = 1'b0;
      tick();
      checks++;
      if (bus.valid !== (f == 0) || bus.data !== (f == 0 ? 8'hA5 : 8'h00)) begin
        failures++;
        $display("FAIL b2b_restart%0d got=v%b d%h exp=v%b", f, bus.valid, bus.data, f == 0);
      end
    end
  endtask

  initial begin
    bus.count0 = 64'h0;
    bus.count1 = 64'h0;
    bus.req = 1'b0;
    bus.ready = 1'b1;
    test_reset();
    test_basic();
    test_snapshot();
    test_ready_toggle();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
